gate_tt_checker: RTL and testbench

//  Active end of the switch-level gate test harness. Drives the two inputs of a 2-input

---
 rtl/gate_chk_pkg.sv | 23 ++
 rtl/gate_chk_hold_timer.sv | 30 +++
 rtl/gate_tt_checker.sv | 129 ++++++++++++
 tb/tb_gate_tt_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
//   state_t    : checker FSM states
//   TT_*       : expected-output tables indexed by {in1,in2}
//   hold_w()   : width of the settle down-counter (never below 1)
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    function automatic int unsigned hold_w(input int unsigned settle);
        return (settle == 0) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/gate_chk_hold_timer.sv
// Loadable settle down-counter.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : reload value
//   expire     : count is 1, so it reaches 0 at the coming edge
// Counts down to 0 and parks there until reloaded.
module gate_chk_hold_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table checker for a 2-input gate DUT.
// Drives {in1,in2} through 00,01,10,11 for PASSES sweeps, holds each vector
// SETTLE_CYCLES cycles before a one-cycle check, and compares dut_out with
// TT[{in1,in2}].
//   clk, rst_n      : clock, async active-low reset
//   start           : begin a run (only looked at in IDLE)
//   dut_out         : gate output under test
//   in1, in2        : gate inputs
//   busy            : run in progress (start-accept edge to final check edge)
//   done            : one-cycle pulse after the final check
//   pass            : last run had no mismatches (held until next start)
//   err_cnt         : saturating mismatch count
//   first_err_vec   : {in1,in2} of the first mismatch
//   first_err_valid : first_err_vec is meaningful
module gate_tt_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0]  TT            = TT_NAND,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_out,
    output logic             in1,
    output logic             in2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       first_err_vec,
    output logic             first_err_valid
);

    localparam int unsigned HW = hold_w(SETTLE_CYCLES);
    localparam int unsigned PW = (PASSES < 2) ? 1 : $clog2(PASSES);
    localparam logic [HW-1:0] SETTLE_V  = HW'(SETTLE_CYCLES);
    localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);
    // With no settle time a vector goes straight to its check cycle.
    localparam state_t AFTER_LOAD = (SETTLE_CYCLES == 0) ? CHECK : HOLD;

    state_t           state;
    logic [1:0]       vec;
    logic [PW-1:0]    pass_cnt;
    logic             load;
    logic             expire;
    logic             expected;
    logic             mismatch;
    logic             last;
    logic [ERR_W-1:0] err_next;

    assign in1 = vec[1];
    assign in2 = vec[0];

    // Case-inequality so a floating or unknown output is a failure.
    assign expected = TT[vec];
    assign mismatch = (dut_out !== expected);
    assign last     = (vec == 2'd3) && (pass_cnt == LAST_PASS);
    assign err_next = (mismatch && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;

    // Reload the settle timer whenever a new vector is applied.
    assign load = ((state == IDLE) && start) || ((state == CHECK) && !last);

    gate_chk_hold_timer #(.W(HW)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (SETTLE_V),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            vec             <= 2'd0;
            pass_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= 2'd0;
            first_err_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec             <= 2'd0;
                        pass_cnt        <= '0;
                        err_cnt         <= '0;
                        first_err_vec   <= 2'd0;
                        first_err_valid <= 1'b0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        state           <= AFTER_LOAD;
                    end
                end
                HOLD: begin
                    if (expire)
                        state <= CHECK;
                end
                CHECK: begin
                    err_cnt <= err_next;
                    if (mismatch && !first_err_valid) begin
                        first_err_vec   <= vec;
                        first_err_valid <= 1'b1;
                    end
                    if (last) begin
                        state <= IDLE;
                        vec   <= 2'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // err_next already includes this final check.
                        pass  <= (err_next == '0);
                    end else begin
                        vec <= vec + 2'd1;
                        if (vec == 2'd3)
                            pass_cnt <= pass_cnt + 1'b1;
                        state <= AFTER_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
module tb_gate_tt_checker;
    import gate_chk_pkg::*;

    // Instance 0: SETTLE=2 PASSES=1 ERR_W=8
    // Instance 1: SETTLE=2 PASSES=4 ERR_W=3
    // Instance 2: SETTLE=0 PASSES=1 ERR_W=8
    localparam int P_SETTLE [3] = '{2, 2, 0};
    localparam int P_PASSES [3] = '{1, 4, 1};
    localparam int P_ERRMAX [3] = '{255, 7, 255};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_s [3];
    int         mode_s  [3];
    logic       dout_s  [3];
    logic       in1_s   [3];
    logic       in2_s   [3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic       pass_s  [3];
    logic       fv_s    [3];
    logic [1:0] fev_s   [3];
    logic [7:0] err_a, err_c;
    logic [2:0] err_b;

    // Switch-level NAND stand-in: 0 good, 1 stuck-at-1, 2 stuck-at-0,
    // 3 pull-down open (output floats on 11).
    function automatic logic gate_model(input int m, input logic a, input logic b);
        case (m)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return (a & b) ? 1'bz : 1'b1;
            default: return ~(a & b);
        endcase
    endfunction

    assign dout_s[0] = gate_model(mode_s[0], in1_s[0], in2_s[0]);
    assign dout_s[1] = gate_model(mode_s[1], in1_s[1], in2_s[1]);
    assign dout_s[2] = gate_model(mode_s[2], in1_s[2], in2_s[2]);

    gate_tt_checker #(.TT(TT_NAND), .SETTLE_CYCLES(2), .PASSES(1), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .dut_out(dout_s[0]),
        .in1(in1_s[0]), .in2(in2_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .err_cnt(err_a), .first_err_vec(fev_s[0]),
        .first_err_valid(fv_s[0])
    );

    gate_tt_checker #(.TT(TT_NAND), .SETTLE_CYCLES(2), .PASSES(4), .ERR_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .dut_out(dout_s[1]),
        .in1(in1_s[1]), .in2(in2_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .err_cnt(err_b), .first_err_vec(fev_s[1]),
        .first_err_valid(fv_s[1])
    );

    gate_tt_checker #(.TT(TT_NAND), .SETTLE_CYCLES(0), .PASSES(1), .ERR_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .dut_out(dout_s[2]),
        .in1(in1_s[2]), .in2(in2_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .pass(pass_s[2]), .err_cnt(err_c), .first_err_vec(fev_s[2]),
        .first_err_valid(fv_s[2])
    );

    typedef struct {
        int         inst;
        int         err;
        logic       pass;
        logic [1:0] fev;
        logic       fv;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] get_err(input int i);
        case (i)
            0:       return 32'(err_a);
            1:       return 32'(err_b);
            default: return 32'(err_c);
        endcase
    endfunction

    // Expected result of one run on instance i with its current fault mode.
    task automatic push_exp(input int i);
        exp_t       e;
        logic [3:0] tt;
        logic [1:0] vv;
        logic       o;
        tt = TT_NAND;
        e.inst = i; e.err = 0; e.fev = 2'd0; e.fv = 1'b0;
        for (int p = 0; p < P_PASSES[i]; p++) begin
            for (int v = 0; v < 4; v++) begin
                vv = 2'(v);
                o = gate_model(mode_s[i], vv[1], vv[0]);
                if (o !== tt[vv]) begin
                    if (e.err < P_ERRMAX[i]) e.err++;
                    if (!e.fv) begin e.fv = 1'b1; e.fev = vv; end
                end
            end
        end
        e.pass = (e.err == 0);
        sb.push_back(e);
    endtask

    // Start must already be driven; waits the accept edge, follows the run,
    // then pops the scoreboard on done.
    task automatic run(input int i, input bit hold, input string tag);
        int   total;
        bit   seen;
        exp_t e;
        total = 4 * P_PASSES[i] * (P_SETTLE[i] + 1);
        seen = 1'b0;
        @(posedge clk);
        for (int k = 0; k < total + 20; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) start_s[i] = 1'b0;
            if (k < total) begin
                chk({tag, "_busy"}, busy_s[i], 1'b1);
                chk({tag, "_vec"}, {in1_s[i], in2_s[i]}, (k / (P_SETTLE[i] + 1)) % 4);
            end
            if (done_s[i]) begin
                seen = 1'b1;
                chk({tag, "_latency"}, k, total);
                break;
            end
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_inst"}, i, e.inst);
            chk({tag, "_err_cnt"}, get_err(i), e.err);
            chk({tag, "_pass"}, pass_s[i], e.pass);
            chk({tag, "_fv"}, fv_s[i], e.fv);
            if (e.fv) chk({tag, "_fev"}, fev_s[i], e.fev);
        end
        chk({tag, "_busy_end"}, busy_s[i], 1'b0);
        chk({tag, "_in_end"}, {in1_s[i], in2_s[i]}, 2'b00);
    endtask

    task automatic chk_idle_zero(input int i, input string tag);
        chk({tag, "_busy"}, busy_s[i], 1'b0);
        chk({tag, "_done"}, done_s[i], 1'b0);
        chk({tag, "_pass"}, pass_s[i], 1'b0);
        chk({tag, "_err"}, get_err(i), 0);
        chk({tag, "_fv"}, fv_s[i], 1'b0);
        chk({tag, "_fev"}, fev_s[i], 2'b00);
        chk({tag, "_in"}, {in1_s[i], in2_s[i]}, 2'b00);
    endtask

    initial begin
        bit saw_done;
        for (int i = 0; i < 3; i++) begin start_s[i] = 1'b0; mode_s[i] = 0; end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle_zero(i, "reset");
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("no_run_pass%0d", i), pass_s[i], 1'b0);

        // Good NAND
        mode_s[0] = 0; push_exp(0);
        start_s[0] = 1'b1;
        run(0, 1'b0, "t1");
        @(negedge clk);
        chk("t1_done_pulse", done_s[0], 1'b0);
        chk("t1_pass_held", pass_s[0], 1'b1);

        // Stuck at 1: only vector 11 mismatches
        mode_s[0] = 1; push_exp(0);
        start_s[0] = 1'b1;
        run(0, 1'b0, "t2");

        // Stuck at 0, four sweeps, 3-bit saturating counter
        @(negedge clk);
        mode_s[1] = 2; push_exp(1);
        start_s[1] = 1'b1;
        run(1, 1'b0, "t3");

        // Floating output on 11
        @(negedge clk);
        mode_s[0] = 3; push_exp(0);
        start_s[0] = 1'b1;
        run(0, 1'b0, "t4");

        // Reset during a run
        @(negedge clk);
        mode_s[0] = 0;
        start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle_zero(0, "t5_abort");
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done_s[0]) saw_done = 1'b1;
        end
        chk("t5_no_done", saw_done, 1'b0);
        chk("t5_idle", busy_s[0], 1'b0);
        push_exp(0);
        start_s[0] = 1'b1;
        run(0, 1'b0, "t5_rerun");

        // Start held high, no settle time: back-to-back runs from the done cycle
        @(negedge clk);
        mode_s[2] = 0;
        push_exp(2);
        push_exp(2);
        start_s[2] = 1'b1;
        run(2, 1'b1, "t6a");
        run(2, 1'b0, "t6b");
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_third", busy_s[2], 1'b0);
        end
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
